// File: rtl/rv32i_types.sv
// Shared types for the L2 writeback buffer.
// Contents:
//   wbuf_state_t - control FSM states (IDLE, READ, DRAIN, RESP)
//   wbuf_entry_t - one buffered dirty line: valid, 27-bit line tag, 256-bit data
//   line_tag()   - strips the 5-bit byte offset from a 32-bit address
package rv32i_types;

  localparam int unsigned LineOffsetW = 5;
  localparam int unsigned TagW        = 27;
  localparam int unsigned LineW       = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } wbuf_state_t;

  typedef struct packed {
    logic             valid;
    logic [TagW-1:0]  tag;
    logic [LineW-1:0] data;
  } wbuf_entry_t;

  function automatic logic [TagW-1:0] line_tag(input logic [31:0] addr);
    return addr[31:LineOffsetW];
  endfunction

endpackage

// File: rtl/wbuf_cam.sv
// Content-addressable storage for the writeback buffer entries.
// Ports:
//   clk, rst               - clock, synchronous active-high reset (clears valid bits)
//   lookup_tag             - line tag to search for
//   match_vec, match_idx   - per-entry hit vector and index of the hitting entry
//   rd_idx, rd_tag, rd_data- indexed read port
//   wr_en, wr_idx, wr_tag, wr_data - write/overwrite port (sets valid)
//   inv_en, inv_idx        - invalidate port
module wbuf_cam
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TagW-1:0]  lookup_tag,
  output logic [DEPTH-1:0] match_vec,
  output logic [IdxW-1:0]  match_idx,
  input  logic [IdxW-1:0]  rd_idx,
  output logic [TagW-1:0]  rd_tag,
  output logic [LineW-1:0] rd_data,
  input  logic             wr_en,
  input  logic [IdxW-1:0]  wr_idx,
  input  logic [TagW-1:0]  wr_tag,
  input  logic [LineW-1:0] wr_data,
  input  logic             inv_en,
  input  logic [IdxW-1:0]  inv_idx
);

  wbuf_entry_t entries_q [DEPTH];

  // Only valid bits are reset; tag/data are don't-care while invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i].valid <= 1'b0;
      end
    end else begin
      if (inv_en) begin
        entries_q[inv_idx].valid <= 1'b0;
      end
      if (wr_en) begin
        entries_q[wr_idx] <= '{valid: 1'b1, tag: wr_tag, data: wr_data};
      end
    end
  end

  // Tags are unique among valid entries, so at most one bit of match_vec is set.
  always_comb begin
    match_vec = '0;
    match_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_vec[i] = entries_q[i].valid && (entries_q[i].tag == lookup_tag);
      if (match_vec[i]) begin
        match_idx = IdxW'(i);
      end
    end
  end

  assign rd_tag  = entries_q[rd_idx].tag;
  assign rd_data = entries_q[rd_idx].data;

endmodule

// File: rtl/l2_writeback_buffer.sv
// Writeback buffer between an L2 cache and a cacheline adaptor. Evicted dirty
// lines are queued (FIFO, DEPTH entries, same-line writes coalesce) and drained
// to memory when the L2 side is idle or when space is needed.
// Build option: define WBUF_FORWARD_EN to serve L2 reads that hit a buffered
// line directly from the buffer; otherwise every read first drains the buffer.
// Ports:
//   clk, rst                                   - clock, synchronous active-high reset
//   l2_address, l2_wdata, l2_read, l2_write     - L2 request (line address, eviction data)
//   l2_rdata, l2_resp                          - fill data, one-cycle completion pulse
//   pmem_address, pmem_wdata, pmem_read, pmem_write - adaptor request (registered)
//   pmem_rdata, pmem_resp                      - adaptor fill data, completion pulse
module l2_writeback_buffer
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  l2_address,
  input  logic [255:0] l2_wdata,
  input  logic         l2_read,
  input  logic         l2_write,
  output logic [255:0] l2_rdata,
  output logic         l2_resp,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  output logic         pmem_read,
  output logic         pmem_write,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  wbuf_state_t state_q, state_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [IdxW-1:0]  head_q, head_d;
  logic [IdxW-1:0]  tail_q, tail_d;
  logic [255:0]     l2_rdata_q, l2_rdata_d;
  logic             pmem_read_q, pmem_read_d;
  logic             pmem_write_q, pmem_write_d;
  logic [31:0]      pmem_address_q, pmem_address_d;
  logic [255:0]     pmem_wdata_q, pmem_wdata_d;

  logic [TagW-1:0]  req_tag;
  logic [DEPTH-1:0] cam_match_vec;
  logic [IdxW-1:0]  cam_match_idx;
  logic             hit;
  logic [IdxW-1:0]  cam_rd_idx;
  logic [TagW-1:0]  cam_rd_tag;
  logic [LineW-1:0] cam_rd_data;
  logic             cam_wr_en;
  logic [IdxW-1:0]  cam_wr_idx;
  logic             cam_inv_en;

  // Byte offset is ignored everywhere.
  logic unused_offset;
  assign unused_offset = ^l2_address[LineOffsetW-1:0];

  assign req_tag = line_tag(l2_address);
  assign hit     = |cam_match_vec;

  // One read port serves both the head (drain) and a forwarding hit; a read
  // request never starts a drain while forwarding is enabled.
`ifdef WBUF_FORWARD_EN
  assign cam_rd_idx = l2_read ? cam_match_idx : head_q;
`else
  assign cam_rd_idx = head_q;
`endif

  wbuf_cam #(
    .DEPTH(DEPTH)
  ) u_cam (
    .clk        (clk),
    .rst        (rst),
    .lookup_tag (req_tag),
    .match_vec  (cam_match_vec),
    .match_idx  (cam_match_idx),
    .rd_idx     (cam_rd_idx),
    .rd_tag     (cam_rd_tag),
    .rd_data    (cam_rd_data),
    .wr_en      (cam_wr_en),
    .wr_idx     (cam_wr_idx),
    .wr_tag     (req_tag),
    .wr_data    (l2_wdata),
    .inv_en     (cam_inv_en),
    .inv_idx    (head_q)
  );

  function automatic logic [IdxW-1:0] ptr_inc(input logic [IdxW-1:0] p);
    if (p == IdxW'(DEPTH - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    head_d         = head_q;
    tail_d         = tail_q;
    l2_rdata_d     = l2_rdata_q;
    pmem_read_d    = pmem_read_q;
    pmem_write_d   = pmem_write_q;
    pmem_address_d = pmem_address_q;
    pmem_wdata_d   = pmem_wdata_q;
    cam_wr_en      = 1'b0;
    cam_wr_idx     = tail_q;
    cam_inv_en     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (l2_read) begin
`ifdef WBUF_FORWARD_EN
          if (hit) begin
            l2_rdata_d = cam_rd_data;
            state_d    = RESP;
          end else begin
            pmem_read_d    = 1'b1;
            pmem_address_d = {req_tag, {LineOffsetW{1'b0}}};
            state_d        = READ;
          end
`else
          // Empty the buffer first so memory holds the newest copy of the line.
          if (count_q != '0) begin
            pmem_write_d   = 1'b1;
            pmem_address_d = {cam_rd_tag, {LineOffsetW{1'b0}}};
            pmem_wdata_d   = cam_rd_data;
            state_d        = DRAIN;
          end else begin
            pmem_read_d    = 1'b1;
            pmem_address_d = {req_tag, {LineOffsetW{1'b0}}};
            state_d        = READ;
          end
`endif
        end else if (l2_write) begin
          if (hit) begin
            cam_wr_en  = 1'b1;
            cam_wr_idx = cam_match_idx;
            state_d    = RESP;
          end else if (count_q < CntW'(DEPTH)) begin
            cam_wr_en  = 1'b1;
            cam_wr_idx = tail_q;
            tail_d     = ptr_inc(tail_q);
            count_d    = count_q + 1'b1;
            state_d    = RESP;
          end else begin
            // Full: free the head slot; the still-pending write is retried in IDLE.
            pmem_write_d   = 1'b1;
            pmem_address_d = {cam_rd_tag, {LineOffsetW{1'b0}}};
            pmem_wdata_d   = cam_rd_data;
            state_d        = DRAIN;
          end
        end else if (count_q != '0) begin
          pmem_write_d   = 1'b1;
          pmem_address_d = {cam_rd_tag, {LineOffsetW{1'b0}}};
          pmem_wdata_d   = cam_rd_data;
          state_d        = DRAIN;
        end
      end
      READ: begin
        if (pmem_resp) begin
          pmem_read_d = 1'b0;
          l2_rdata_d  = pmem_rdata;
          state_d     = RESP;
        end
      end
      DRAIN: begin
        if (pmem_resp) begin
          pmem_write_d = 1'b0;
          cam_inv_en   = 1'b1;
          head_d       = ptr_inc(head_q);
          count_d      = count_q - 1'b1;
          state_d      = IDLE;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      count_q        <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      l2_rdata_q     <= '0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      l2_rdata_q     <= l2_rdata_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
    end
  end

  assign l2_resp      = (state_q == RESP);
  assign l2_rdata     = l2_rdata_q;
  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;

  ap_no_rd_wr_together: assert property (@(posedge clk) disable iff (rst)
    !(l2_read && l2_write));
  ap_pmem_exclusive: assert property (@(posedge clk) !(pmem_read && pmem_write));

endmodule

// File: tb/tb_l2_writeback_buffer.sv
// Self-checking bench for l2_writeback_buffer (DEPTH=2). Works with or without
// WBUF_FORWARD_EN; expected values differ per build where the behaviour does.
module tb_l2_writeback_buffer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  l2_address = '0;
  logic [255:0] l2_wdata = '0;
  logic         l2_read = 1'b0;
  logic         l2_write = 1'b0;
  logic [255:0] l2_rdata;
  logic         l2_resp;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_rdata = '0;
  logic         pmem_resp = 1'b0;

  always #5 clk = ~clk;

  l2_writeback_buffer #(.DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .l2_address   (l2_address),
    .l2_wdata     (l2_wdata),
    .l2_read      (l2_read),
    .l2_write     (l2_write),
    .l2_rdata     (l2_rdata),
    .l2_resp      (l2_resp),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] mk(input logic [31:0] seed);
    return {8{seed}};
  endfunction

  // Data returned by memory for lines never written.
  function automatic logic [255:0] pat(input logic [31:0] addr);
    return {8{addr ^ 32'hC0DE_0000}};
  endfunction

  // ---------------- memory model + expected-write scoreboard ----------------
  typedef struct {
    logic [31:0]  addr;
    logic [255:0] data;
  } wr_t;

  logic [255:0] mem [logic [31:0]];
  wr_t          exp_wq[$];
  int           pmem_rd_cnt = 0;
  int           pmem_wr_cnt = 0;
  int unsigned  last_presp_cyc = 0;
  int           plat = 7;

  always begin : pmem_model
    logic [31:0]  a;
    logic [255:0] d;
    logic         is_rd;
    bit           aborted;
    wr_t          e;
    @(negedge clk);
    if (!rst && (pmem_read || pmem_write)) begin
      a = pmem_address;
      d = pmem_wdata;
      is_rd = pmem_read;
      aborted = 1'b0;
      for (int k = 0; k < plat; k++) begin
        @(posedge clk);
        if (rst) begin
          aborted = 1'b1;
          break;
        end
      end
      if (!aborted) begin
        #1;
        check("pmem_hold", {222'd0, pmem_read, pmem_write, pmem_address},
              {222'd0, is_rd, !is_rd, a});
        if (is_rd) begin
          pmem_rdata = mem.exists(a) ? mem[a] : pat(a);
          pmem_rd_cnt++;
        end else begin
          mem[a] = d;
          pmem_wr_cnt++;
          if (exp_wq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL pmem_wr_unexpected: got write addr %0h, required none", a);
          end else begin
            e = exp_wq.pop_front();
            check("pmem_wr_addr", {224'd0, a}, {224'd0, e.addr});
            check("pmem_wr_data", d, e.data);
          end
        end
        pmem_resp = 1'b1;
        last_presp_cyc = cyc;
        @(posedge clk);
        #1 pmem_resp = 1'b0;
      end
    end
  end

  // ---------------- protocol monitors ----------------
  logic resp_prev = 1'b0;
  always @(negedge clk) begin
    if (l2_resp) check("l2_resp_pulse", {255'd0, resp_prev}, 256'd0);
    if (pmem_read || pmem_write) check("pmem_excl", {255'd0, pmem_read & pmem_write}, 256'd0);
    resp_prev = l2_resp;
  end

  // ---------------- L2-side driver with read-data scoreboard ----------------
  logic [255:0] rd_q[$];

  task automatic l2_op(input string name, input bit rd, input logic [31:0] addr,
                       input logic [255:0] wd, input logic [255:0] exp_rd,
                       output bit ok, output int unsigned resp_cyc);
    int n;
    logic [255:0] exp;
    l2_read = rd;
    l2_write = !rd;
    l2_address = addr;
    l2_wdata = wd;
    if (rd) rd_q.push_back(exp_rd);
    n = 0;
    ok = 1'b0;
    while (n < 400) begin
      @(negedge clk);
      if (l2_resp) begin
        ok = 1'b1;
        break;
      end
      n++;
    end
    resp_cyc = cyc;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_timeout: no l2_resp within %0d cycles, required one", name, n);
    end
    if (rd) begin
      exp = rd_q.pop_front();
      if (ok) check({name, "_rdata"}, l2_rdata, exp);
    end
    @(posedge clk);
    #1;
    l2_read = 1'b0;
    l2_write = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit           rd;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic [255:0] exp_rdata;
    int           exp_cnt;
    int           exp_prd;
    int           exp_pwr;
    int           exp_lat;
  } vec_t;

  localparam int NVec = 9;
  vec_t vecs[NVec];

  task automatic set_vec(input int i, input bit rd, input logic [31:0] addr,
                         input logic [255:0] wd, input logic [255:0] er,
                         input int cnt, input int prd, input int pwr, input int lat);
    vecs[i].rd = rd;
    vecs[i].addr = addr;
    vecs[i].wdata = wd;
    vecs[i].exp_rdata = er;
    vecs[i].exp_cnt = cnt;
    vecs[i].exp_prd = prd;
    vecs[i].exp_pwr = pwr;
    vecs[i].exp_lat = lat;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [255:0] da, db, dc, dd, de, da2, df;
    bit ok;
    int unsigned s, rc;
    int prd0, pwr0, n, exp_rd_total;
    logic strobe_seen;

    da  = mk(32'hA0A0_0001);
    db  = mk(32'hB0B0_0002);
    dc  = mk(32'hC0C0_0003);
    dd  = mk(32'hD0D0_0004);
    de  = mk(32'hE0E0_0005);
    da2 = mk(32'hA2A2_0009);
    df  = mk(32'hF0F0_0006);

    // rd, addr, wdata, exp_rdata, count, pmem reads, pmem writes, latency
    set_vec(0, 0, 32'h0000_0100, da, '0, 1, 0, 0, 1);
    set_vec(1, 0, 32'h0000_0200, db, '0, 2, 0, 0, 1);
    set_vec(2, 0, 32'h0000_0200, dc, '0, 2, 0, 0, 1);
    set_vec(3, 0, 32'h0000_0300, dd, '0, 2, 0, 1, 10);
    set_vec(4, 0, 32'h0000_031F, de, '0, 2, 0, 0, 1);
`ifdef WBUF_FORWARD_EN
    set_vec(5, 1, 32'h0000_0204, '0, dc, 2, 0, 0, 1);
    set_vec(6, 1, 32'h0000_4010, '0, pat(32'h0000_4000), 2, 1, 0, 9);
    set_vec(7, 0, 32'h0000_1040, da2, '0, 2, 0, 1, 10);
    set_vec(8, 1, 32'h0000_1044, '0, da2, 2, 0, 0, 1);
    exp_rd_total = 1;
`else
    set_vec(5, 1, 32'h0000_0204, '0, dc, 0, 1, 2, 27);
    set_vec(6, 1, 32'h0000_4010, '0, pat(32'h0000_4000), 0, 1, 0, 9);
    set_vec(7, 0, 32'h0000_1040, da2, '0, 1, 0, 0, 1);
    set_vec(8, 1, 32'h0000_1044, '0, da2, 0, 1, 1, 18);
    exp_rd_total = 3;
`endif
    // Drain order is the same in both builds; coalesced data wins.
    exp_wq.push_back('{addr: 32'h0000_0100, data: da});
    exp_wq.push_back('{addr: 32'h0000_0200, data: dc});
    exp_wq.push_back('{addr: 32'h0000_0300, data: de});
    exp_wq.push_back('{addr: 32'h0000_1040, data: da2});

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_l2_resp", {255'd0, l2_resp}, 256'd0);
    check("rst_l2_rdata", l2_rdata, 256'd0);
    check("rst_pmem_strobes", {254'd0, pmem_read, pmem_write}, 256'd0);
    check("rst_pmem_address", {224'd0, pmem_address}, 256'd0);
    check("rst_pmem_wdata", pmem_wdata, 256'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Back-to-back table: no idle cycle between requests, so no background drains.
    for (int i = 0; i < NVec; i++) begin
      prd0 = pmem_rd_cnt;
      pwr0 = pmem_wr_cnt;
      s = cyc;
      l2_op($sformatf("v%0d", i), vecs[i].rd, vecs[i].addr, vecs[i].wdata,
            vecs[i].exp_rdata, ok, rc);
      if (ok) begin
        check($sformatf("v%0d_count", i), 256'(dut.count_q), 256'(vecs[i].exp_cnt));
        check($sformatf("v%0d_pmem_reads", i), 256'(pmem_rd_cnt - prd0), 256'(vecs[i].exp_prd));
        check($sformatf("v%0d_pmem_writes", i), 256'(pmem_wr_cnt - pwr0), 256'(vecs[i].exp_pwr));
        check($sformatf("v%0d_latency", i), 256'(rc - s), 256'(vecs[i].exp_lat));
        if (vecs[i].exp_prd > 0)
          check($sformatf("v%0d_resp_after_pmem", i), 256'(rc), 256'(last_presp_cyc + 1));
      end
    end

    // Idle: whatever is left drains on its own.
    n = 0;
    while (pmem_wr_cnt < 4 && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    check("drain_total_writes", 256'(pmem_wr_cnt), 256'd4);
    check("drain_exp_queue_empty", 256'(exp_wq.size()), 256'd0);
    check("drain_count_zero", 256'(dut.count_q), 256'd0);
    check("total_pmem_reads", 256'(pmem_rd_cnt), 256'(exp_rd_total));

    // Reset in the middle of a drain.
    @(posedge clk);
    #1;
    l2_op("rst_push", 1'b0, 32'h0000_0500, df, '0, ok, rc);
    n = 0;
    while (!pmem_write && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_drain_started", {255'd0, pmem_write}, 256'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_pmem_write", {255'd0, pmem_write}, 256'd0);
    check("rst_mid_count", 256'(dut.count_q), 256'd0);
    check("rst_mid_pmem_address", {224'd0, pmem_address}, 256'd0);
    strobe_seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      strobe_seen = strobe_seen | pmem_read | pmem_write;
    end
    check("rst_no_strobe", {255'd0, strobe_seen}, 256'd0);
    check("rst_no_write_done", 256'(pmem_wr_cnt), 256'd4);
    @(posedge clk);
    #1;
    prd0 = pmem_rd_cnt;
    s = cyc;
    l2_op("rst_read", 1'b1, 32'h0000_0500, '0, pat(32'h0000_0500), ok, rc);
    check("rst_read_to_pmem", 256'(pmem_rd_cnt - prd0), 256'd1);
    check("rst_read_latency", 256'(rc - s), 256'd9);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l2_writeback_buffer.md
L2_WRITEBACK_BUFFER -- requirements
Module: l2_writeback_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of buffered dirty lines (legal 1..8).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports l2_address input 32, l2_wdata input 256, l2_read input 1, l2_write input 1: L2-side request; line address, eviction data, read/write strobes.
REQ-005 SHALL have ports l2_rdata output 256, l2_resp output 1: fill data to L2; one-cycle completion pulse.
REQ-006 SHALL have ports pmem_address output 32, pmem_wdata output 256, pmem_read output 1, pmem_write output 1: cacheline-adaptor request.
REQ-007 SHALL have ports pmem_rdata input 256, pmem_resp input 1: adaptor fill data; completion pulse.

Function
REQ-008 SHALL treat addresses as line addresses; bits [4:0] forced to zero in storage, compares and pmem_address.
REQ-009 SHALL implement states IDLE, READ, DRAIN, RESP.
REQ-010 SHALL, in IDLE, prioritise: l2_read, then l2_write, then drain of a non-empty buffer.
REQ-011 SHALL, on l2_read in IDLE whose address matches a valid entry, load that entry's data into l2_rdata and go to RESP (l2_resp high the next cycle).
REQ-012 SHALL, on l2_read miss in IDLE, go to READ; pmem_read and pmem_address held from next cycle until pmem_resp; on pmem_resp latch pmem_rdata into l2_rdata, go to RESP.
REQ-013 SHALL, on l2_write in IDLE matching a valid entry, overwrite that entry's data (coalesce), count unchanged, go to RESP.
REQ-014 SHALL, on l2_write in IDLE with no match and count<DEPTH, push to tail, count+1, go to RESP.
REQ-015 SHALL, on l2_write with no match and count==DEPTH, go to DRAIN of the head entry; the write is accepted only after a slot frees.
REQ-016 SHALL, in DRAIN, hold pmem_write, pmem_address, pmem_wdata from head entry until pmem_resp, then pop head, count-1, return to IDLE; DRAIN is never aborted.
REQ-017 SHALL assert l2_resp for exactly one cycle (RESP), then return to IDLE; requests are not sampled while l2_resp is high.
REQ-018 SHALL never assert pmem_read and pmem_write together.
REQ-019 SHALL treat simultaneous l2_read and l2_write as illegal (simulation assertion); read is served.
REQ-020 SHALL implement head/tail pointers wrapping modulo DEPTH; entries drain in FIFO order.

Reset
REQ-021 SHALL on rst: state IDLE, count 0, pointers 0, all valid bits 0, l2_resp 0, l2_rdata 0, pmem_read 0, pmem_write 0, pmem_address 0, pmem_wdata 0, all effective the next cycle.
REQ-022 SHALL discard buffered lines and any outstanding pmem transaction on rst mid-operation; no further pmem strobe until a new request.

Configuration
REQ-023 SHALL use macro WBUF_FORWARD_EN: defined -> REQ-011 forwarding active; undefined -> any l2_read drains the whole buffer (repeated DRAIN) before READ, and no entry is ever compared for reads.

Structure
REQ-024 SHALL place wbuf_state_t enum and wbuf_entry_t struct (valid, tag[26:0], data[255:0]) in rv32i_types.
REQ-025 SHALL use one sub-module wbuf_cam: DEPTH entries, match vector and match index for a given line address, write/overwrite port.

Verification
REQ-026 SHALL cover: write 0x0000_1040 data A, empty buffer -> l2_resp 1 cycle later, count 1, no pmem_write until idle.
REQ-027 SHALL cover: after REQ-026, read 0x0000_1044 (forward on) -> l2_rdata=A, l2_resp next cycle, pmem_read never asserted.
REQ-028 SHALL cover: DEPTH=2 full (0x100, 0x200), write 0x300 -> pmem_write addr 0x100 first, then l2_resp; buffer holds 0x200, 0x300.
REQ-029 SHALL cover: write 0x200 twice with data B then C -> count 1, drain writes C once.
REQ-030 SHALL cover: read miss 0x4000, pmem_resp after 7 cycles -> l2_rdata=pmem_rdata, l2_resp exactly 1 cycle after pmem_resp.
REQ-031 SHALL cover: rst asserted mid-DRAIN -> pmem_write 0 next cycle, count 0, subsequent read of drained address goes to pmem.
